// File: rtl/ast_systolic_tile_sv.sv
// rtl/ast_systolic_tile_sv.sv - self-sequencing output-stationary systolic tile, D = A*B
// Skewed operand feed, wrapping signed accumulators, internal flush and row-serial drain.
module ast_systolic_tile_sv #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int DATAWIDTH = 14,
    parameter int ACCWIDTH  = 32,
    parameter int KWIDTH    = 8,
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               start,
    input  logic [KWIDTH-1:0]                  k_len,
    output logic                               busy,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [ROWS-1:0][DATAWIDTH-1:0]     a_in,
    input  logic [COLS-1:0][DATAWIDTH-1:0]     b_in,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [RW-1:0]                      out_row,
    output logic [COLS-1:0][ACCWIDTH-1:0]      d_out,
    output logic                               done
);
    localparam int DW = DATAWIDTH;
    localparam int FW = $clog2(ROWS + COLS);

    typedef enum logic [1:0] {S_IDLE, S_FEED, S_FLUSH, S_DRAIN} state_t;

    state_t              state_q;
    logic [KWIDTH-1:0]   k_q, beat_q;
    logic [FW-1:0]       flush_q;
    logic [RW-1:0]       row_q;
    logic                busy_q, in_ready_q, out_valid_q, done_q;

    logic job_start, beat, acc_en;
    assign job_start = (state_q == S_IDLE) && start && (k_len != '0);
    assign beat      = (state_q == S_FEED) && in_valid;
    assign acc_en    = (state_q == S_FEED) || (state_q == S_FLUSH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            beat_q      <= '0;
            flush_q     <= '0;
            row_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: if (job_start) begin
                    k_q        <= k_len;
                    beat_q     <= '0;
                    busy_q     <= 1'b1;
                    in_ready_q <= 1'b1;
                    state_q    <= S_FEED;
                end
                S_FEED: if (in_valid) begin
                    if (beat_q == k_q - KWIDTH'(1)) begin
                        in_ready_q <= 1'b0;
                        flush_q    <= '0;
                        state_q    <= S_FLUSH;
                    end else begin
                        beat_q <= beat_q + KWIDTH'(1);
                    end
                end
                // Last product reaches PE(ROWS-1,COLS-1) on the edge that leaves FLUSH.
                S_FLUSH: if (flush_q == FW'(ROWS + COLS - 2)) begin
                    row_q       <= '0;
                    out_valid_q <= 1'b1;
                    state_q     <= S_DRAIN;
                end else begin
                    flush_q <= flush_q + FW'(1);
                end
                S_DRAIN: if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        row_q       <= '0;
                        state_q     <= S_IDLE;
                    end else begin
                        row_q <= row_q + RW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [DW-1:0] a_gated [ROWS];
    logic [DW-1:0] b_gated [COLS];
    logic [DW-1:0] a_skew  [ROWS];
    logic [DW-1:0] b_skew  [COLS];

    always_comb begin
        for (int i = 0; i < ROWS; i++) a_gated[i] = beat ? a_in[i] : '0;
        for (int j = 0; j < COLS; j++) b_gated[j] = beat ? b_in[j] : '0;
    end

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign a_skew[gi] = a_gated[gi];
        end else begin : g_dly
            logic [DW-1:0] sk_q [gi];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset || job_start) begin
                    for (int m = 0; m < gi; m++) sk_q[m] <= '0;
                end else begin
                    sk_q[0] <= a_gated[gi];
                    for (int m = 1; m < gi; m++) sk_q[m] <= sk_q[m-1];
                end
            end
            assign a_skew[gi] = sk_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign b_skew[gj] = b_gated[gj];
        end else begin : g_dly
            logic [DW-1:0] sk_q [gj];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset || job_start) begin
                    for (int m = 0; m < gj; m++) sk_q[m] <= '0;
                end else begin
                    sk_q[0] <= b_gated[gj];
                    for (int m = 1; m < gj; m++) sk_q[m] <= sk_q[m-1];
                end
            end
            assign b_skew[gj] = sk_q[gj-1];
        end
    end

    logic [DW-1:0]              a_q   [ROWS][COLS];
    logic [DW-1:0]              b_q   [ROWS][COLS];
    logic signed [ACCWIDTH-1:0] acc_q [ROWS][COLS];
    logic signed [ACCWIDTH-1:0] prod  [ROWS][COLS];

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_prow
        for (genvar gj = 0; gj < COLS; gj++) begin : g_pcol
            logic signed [2*DW-1:0] p2;
            assign p2 = $signed({{DW{a_q[gi][gj][DW-1]}}, a_q[gi][gj]})
                      * $signed({{DW{b_q[gi][gj][DW-1]}}, b_q[gi][gj]});
            assign prod[gi][gj] = ACCWIDTH'(p2);
        end
    end

    // a_q/b_q hold the operand each PE consumes; they also form the right/down links.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset || job_start) begin
            for (int i = 0; i < ROWS; i++)
                for (int j = 0; j < COLS; j++) begin
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                    acc_q[i][j] <= '0;
                end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                a_q[i][0] <= a_skew[i];
                for (int j = 1; j < COLS; j++) a_q[i][j] <= a_q[i][j-1];
            end
            for (int j = 0; j < COLS; j++) begin
                b_q[0][j] <= b_skew[j];
                for (int i = 1; i < ROWS; i++) b_q[i][j] <= b_q[i-1][j];
            end
            if (acc_en)
                for (int i = 0; i < ROWS; i++)
                    for (int j = 0; j < COLS; j++)
                        acc_q[i][j] <= acc_q[i][j] + prod[i][j];
        end
    end

    always_comb begin
        for (int j = 0; j < COLS; j++) d_out[j] = out_valid_q ? acc_q[row_q][j] : '0;
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_row   = row_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ast_systolic_tile_sv.sv
// tb/tb_ast_systolic_tile_sv.sv - directed self-checking bench for ast_systolic_tile_sv
module tb_ast_systolic_tile_sv;
    localparam int R = 4, C = 4, DW = 14, AW = 32, KW = 8;

    logic                  clk, reset, start, busy, in_valid, in_ready;
    logic                  out_valid, out_ready, done;
    logic [KW-1:0]         k_len;
    logic [R-1:0][DW-1:0]  a_in;
    logic [C-1:0][DW-1:0]  b_in;
    logic [1:0]            out_row;
    logic [C-1:0][AW-1:0]  d_out;

    int total = 0, bad = 0, cyc = 0, s_cyc = 0, l_cyc = 0;

    ast_systolic_tile_sv #(.ROWS(R), .COLS(C), .DATAWIDTH(DW), .ACCWIDTH(AW), .KWIDTH(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .a_in(a_in), .b_in(b_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .d_out(d_out), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int a_val(int mode, int i, int k);
        case (mode)
            0:       return (i == k) ? 1 : 0;
            1:       return -3;
            2:       return -8192;
            default: return i + 1 - 3 * k;
        endcase
    endfunction

    function automatic int b_val(int mode, int k, int j);
        case (mode)
            0:       return 4 * k + j + 1;
            1:       return 5;
            2:       return -8192;
            default: return 2 * j - k - 1;
        endcase
    endfunction

    function automatic logic [31:0] exp_d(int mode, int k, int i, int j);
        longint s = 0;
        for (int kk = 0; kk < k; kk++)
            s += longint'(a_val(mode, i, kk)) * longint'(b_val(mode, kk, j));
        return s[31:0];
    endfunction

    task automatic start_job(input int k);
        start = 1'b1;
        k_len = KW'(k);
        s_cyc = cyc;
        tick();
        start = 1'b0;
        k_len = '0;
    endtask

    task automatic feed(input int k, input int mode, input bit bubbles);
        int bk = 0, guard = 0;
        bit acc;
        while (bk < k && guard < 4 * k + 20) begin
            in_valid = bubbles ? ((guard % 2) == 0) : 1'b1;
            for (int i = 0; i < R; i++) a_in[i] = DW'(a_val(mode, i, bk));
            for (int j = 0; j < C; j++) b_in[j] = DW'(b_val(mode, bk, j));
            acc = in_valid && in_ready;
            if (acc) l_cyc = cyc;
            tick();
            if (acc) bk++;
            guard++;
        end
        in_valid = 1'b0;
        a_in = '0;
        b_in = '0;
        chk("beats_fed", 64'(bk), 64'(k));
        chk("in_ready_fall", 64'(in_ready), 64'd0);
    endtask

    task automatic wait_valid(input int exp_lat);
        int n = 0;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        chk("out_valid_seen", 64'(out_valid), 64'd1);
        chk("first_valid_lat", 64'(cyc - l_cyc), 64'(exp_lat));
    endtask

    task automatic drain(input int mode, input int k, input int pattern, input bit start_poke);
        int r = 0, p = 0;
        bit rdy;
        while (r < R && p < 100) begin
            rdy = (pattern == 0) ? 1'b1 : ((p % 3) == 0);
            out_ready = rdy;
            start = start_poke && (p == 0);
            k_len = start ? KW'(5) : '0;
            chk("drain_valid", 64'(out_valid), 64'd1);
            chk("out_row", 64'(out_row), 64'(r));
            for (int j = 0; j < C; j++) chk("d_out", 64'(d_out[j]), 64'(exp_d(mode, k, r, j)));
            tick();
            if (rdy) r++;
            p++;
        end
        out_ready = 1'b0;
        start = 1'b0;
        k_len = '0;
        chk("rows_drained", 64'(r), 64'(R));
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("valid_at_done", 64'(out_valid), 64'd0);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; k_len = '0; in_valid = 1'b0;
        out_ready = 1'b0; a_in = '0; b_in = '0;
        tick(); tick();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_row", 64'(out_row), 64'd0);
        chk("rst_d_out_zero", 64'(d_out == '0), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b1;
        tick();

        // identity times B, no bubbles, no backpressure
        start_job(4);
        chk("in_ready_rise", 64'(in_ready), 64'd1);
        chk("busy_rise", 64'(busy), 64'd1);
        feed(4, 0, 1'b0);
        wait_valid(8);
        drain(0, 4, 0, 1'b0);
        chk("done_latency", 64'(cyc - s_cyc), 64'd16);
        tick();
        chk("done_one_cycle", 64'(done), 64'd0);

        // same operands with in_valid low on alternate cycles
        start_job(4);
        feed(4, 0, 1'b1);
        wait_valid(8);
        drain(0, 4, 0, 1'b0);
        tick();

        // K=1 sign check, start poked during DRAIN must be ignored
        start_job(1);
        feed(1, 1, 1'b0);
        wait_valid(8);
        drain(1, 1, 0, 1'b1);
        tick();
        chk("start_in_drain_ignored", 64'(busy), 64'd0);

        // accumulator wraparound, K=255 of (-8192)^2
        start_job(255);
        feed(255, 2, 1'b0);
        wait_valid(8);
        chk("overflow_value", 64'(d_out[0]), 64'hFC00_0000);
        drain(2, 255, 0, 1'b0);
        tick();

        // backpressure 1,0,0 repeating
        start_job(4);
        feed(4, 0, 1'b0);
        wait_valid(8);
        drain(0, 4, 1, 1'b0);
        tick();
        chk("bp_done_low", 64'(done), 64'd0);

        // asynchronous reset in FLUSH, then a fresh K=2 job
        start_job(4);
        feed(4, 1, 1'b0);
        tick(); tick();
        chk("in_flush_busy", 64'(busy), 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_in_ready", 64'(in_ready), 64'd0);
        chk("arst_out_valid", 64'(out_valid), 64'd0);
        chk("arst_out_row", 64'(out_row), 64'd0);
        chk("arst_d_out_zero", 64'(d_out == '0), 64'd1);
        chk("arst_done", 64'(done), 64'd0);
        tick();
        reset = 1'b1;
        tick();
        start_job(2);
        feed(2, 3, 1'b0);
        wait_valid(8);
        drain(3, 2, 0, 1'b0);
        tick();

        // k_len = 0 start is ignored
        start = 1'b1;
        k_len = '0;
        tick();
        start = 1'b0;
        chk("k0_busy", 64'(busy), 64'd0);
        chk("k0_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("k0_busy_later", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
